mem_stage: RTL and testbench

//  Consumer end of the execute->memory interface in the RV64IM pipeline. Accepts one

---
 rtl/mem_stage_if.sv | 50 +++++
 rtl/mem_stage.sv | 216 +++++++++++++++++++++
 tb/tb_mem_stage.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Execute->memory->writeback signal bundle for mem_stage; slave = the stage, master = its environment.
// misaligned_o exists only when MEM_MISALIGN_TRAP_EN is defined.
interface mem_stage_if;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [4:0]  rf_rd_i;
  logic        rf_wen_i;
  logic [63:0] aluout_i;
  logic [63:0] store_data_i;
  logic [3:0]  memop_i;
  logic [63:0] pc_i;
  logic        exit_i;
  logic        dmem_req_valid_o;
  logic        dmem_req_ready_i;
  logic [63:0] dmem_addr_o;
  logic        dmem_wen_o;
  logic [63:0] dmem_wdata_o;
  logic [7:0]  dmem_wstrb_o;
  logic        dmem_resp_valid_i;
  logic [63:0] dmem_rdata_i;
  logic        out_valid_o;
  logic [4:0]  rf_rd_o;
  logic        rf_wen_o;
  logic [63:0] rf_wdata_o;
  logic [63:0] pc_o;
  logic        exit_o;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misaligned_o;
`endif

  modport slave (
    input  in_valid_i, rf_rd_i, rf_wen_i, aluout_i, store_data_i, memop_i, pc_i, exit_i,
           dmem_req_ready_i, dmem_resp_valid_i, dmem_rdata_i,
    output in_ready_o, dmem_req_valid_o, dmem_addr_o, dmem_wen_o, dmem_wdata_o, dmem_wstrb_o,
           out_valid_o, rf_rd_o, rf_wen_o, rf_wdata_o, pc_o, exit_o
`ifdef MEM_MISALIGN_TRAP_EN
         , misaligned_o
`endif
  );

  modport master (
    output in_valid_i, rf_rd_i, rf_wen_i, aluout_i, store_data_i, memop_i, pc_i, exit_i,
           dmem_req_ready_i, dmem_resp_valid_i, dmem_rdata_i,
    input  in_ready_o, dmem_req_valid_o, dmem_addr_o, dmem_wen_o, dmem_wdata_o, dmem_wstrb_o,
           out_valid_o, rf_rd_o, rf_wen_o, rf_wdata_o, pc_o, exit_o
`ifdef MEM_MISALIGN_TRAP_EN
         , misaligned_o
`endif
  );
endinterface

// File: rtl/mem_stage.sv
// RV64 memory stage: one instruction per handshake, loads/stores over a valid/ready dmem port, registered writeback.
// Define MEM_MISALIGN_TRAP_EN to report misaligned accesses on misaligned_o instead of forcing alignment.
module mem_stage #(
  parameter int XLEN    = 64,
  parameter int MEMOP_W = 4
) (
  input logic        clk,
  input logic        rst,
  mem_stage_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  state_e              state_q, state_d;
  logic [4:0]          rd_q, rd_d;
  logic                wen_q, wen_d;
  logic [MEMOP_W-1:0]  memop_q, memop_d;
  logic [2:0]          off_q, off_d;
  logic [XLEN-1:0]     addr_q, addr_d, wdata_q, wdata_d, pc_q, pc_d;
  logic [7:0]          wstrb_q, wstrb_d;
  logic                store_q, store_d, exit_q, exit_d;

  logic                out_vld_q, out_vld_d;
  logic [4:0]          o_rd_q, o_rd_d;
  logic                o_wen_q, o_wen_d;
  logic [XLEN-1:0]     o_wdata_q, o_wdata_d, o_pc_q, o_pc_d;
  logic                o_exit_q, o_exit_d;
`ifdef MEM_MISALIGN_TRAP_EN
  logic                mis_q, mis_d;
`endif

  logic                in_load, in_store, in_mis;
  logic [1:0]          in_lsz;
  logic [2:0]          in_mask, in_off;
  logic [7:0]          in_strb;
  logic [XLEN-1:0]     lane, ld_val;

  always_comb begin
    in_load  = bus.memop_i inside {[4'd1:4'd7]};
    in_store = bus.memop_i inside {[4'd8:4'd11]};
    case (bus.memop_i)
      4'd1, 4'd5, 4'd8:  in_lsz = 2'd0;
      4'd2, 4'd6, 4'd9:  in_lsz = 2'd1;
      4'd3, 4'd7, 4'd10: in_lsz = 2'd2;
      default:           in_lsz = 2'd3;
    endcase
    case (in_lsz)
      2'd0:    begin in_mask = 3'b000; in_strb = 8'h01; end
      2'd1:    begin in_mask = 3'b001; in_strb = 8'h03; end
      2'd2:    begin in_mask = 3'b011; in_strb = 8'h0F; end
      default: begin in_mask = 3'b111; in_strb = 8'hFF; end
    endcase
    // Low address bits below the access size are dropped, so the lane is always size-aligned.
    in_off = bus.aluout_i[2:0] & ~in_mask;
`ifdef MEM_MISALIGN_TRAP_EN
    in_mis = (in_load | in_store) & (|(bus.aluout_i[2:0] & in_mask));
`else
    in_mis = 1'b0;
`endif
  end

  always_comb begin
    lane = bus.dmem_rdata_i >> {off_q, 3'b000};
    case (memop_q)
      4'd1:    ld_val = {{56{lane[7]}},  lane[7:0]};
      4'd2:    ld_val = {{48{lane[15]}}, lane[15:0]};
      4'd3:    ld_val = {{32{lane[31]}}, lane[31:0]};
      4'd5:    ld_val = {56'd0, lane[7:0]};
      4'd6:    ld_val = {48'd0, lane[15:0]};
      4'd7:    ld_val = {32'd0, lane[31:0]};
      default: ld_val = lane;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    wen_d     = wen_q;
    memop_d   = memop_q;
    off_d     = off_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    store_d   = store_q;
    pc_d      = pc_q;
    exit_d    = exit_q;
    out_vld_d = 1'b0;
    o_rd_d    = o_rd_q;
    o_wen_d   = o_wen_q;
    o_wdata_d = o_wdata_q;
    o_pc_d    = o_pc_q;
    o_exit_d  = o_exit_q;
`ifdef MEM_MISALIGN_TRAP_EN
    mis_d     = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid_i) begin
          rd_d    = bus.rf_rd_i;
          wen_d   = bus.rf_wen_i & (|bus.rf_rd_i) & ~in_store;
          memop_d = bus.memop_i;
          off_d   = in_off;
          addr_d  = {bus.aluout_i[63:3], 3'b000};
          wdata_d = bus.store_data_i << {in_off, 3'b000};
          wstrb_d = in_store ? (in_strb << in_off) : 8'h00;
          store_d = in_store;
          pc_d    = bus.pc_i;
          exit_d  = bus.exit_i;
          if ((in_load | in_store) & ~in_mis) begin
            state_d = S_REQ;
          end else begin
            out_vld_d = 1'b1;
            o_rd_d    = bus.rf_rd_i;
            o_wen_d   = bus.rf_wen_i & (|bus.rf_rd_i) & ~in_mis;
            o_wdata_d = bus.aluout_i;
            o_pc_d    = bus.pc_i;
            o_exit_d  = bus.exit_i;
`ifdef MEM_MISALIGN_TRAP_EN
            mis_d     = in_mis;
`endif
          end
        end
      end
      S_REQ: begin
        if (bus.dmem_req_ready_i) begin
          if (store_q) begin
            state_d   = S_IDLE;
            out_vld_d = 1'b1;
            o_rd_d    = rd_q;
            o_wen_d   = 1'b0;
            o_wdata_d = '0;
            o_pc_d    = pc_q;
            o_exit_d  = exit_q;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (bus.dmem_resp_valid_i) begin
          state_d   = S_IDLE;
          out_vld_d = 1'b1;
          o_rd_d    = rd_q;
          o_wen_d   = wen_q;
          o_wdata_d = ld_val;
          o_pc_d    = pc_q;
          o_exit_d  = exit_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rd_q      <= '0;
      wen_q     <= 1'b0;
      memop_q   <= '0;
      off_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      store_q   <= 1'b0;
      pc_q      <= '0;
      exit_q    <= 1'b0;
      out_vld_q <= 1'b0;
      o_rd_q    <= '0;
      o_wen_q   <= 1'b0;
      o_wdata_q <= '0;
      o_pc_q    <= '0;
      o_exit_q  <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      wen_q     <= wen_d;
      memop_q   <= memop_d;
      off_q     <= off_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      store_q   <= store_d;
      pc_q      <= pc_d;
      exit_q    <= exit_d;
      out_vld_q <= out_vld_d;
      o_rd_q    <= o_rd_d;
      o_wen_q   <= o_wen_d;
      o_wdata_q <= o_wdata_d;
      o_pc_q    <= o_pc_d;
      o_exit_q  <= o_exit_d;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_q     <= mis_d;
`endif
    end
  end

  assign bus.in_ready_o       = (state_q == S_IDLE);
  assign bus.dmem_req_valid_o = (state_q == S_REQ);
  assign bus.dmem_addr_o      = addr_q;
  assign bus.dmem_wen_o       = store_q;
  assign bus.dmem_wdata_o     = wdata_q;
  assign bus.dmem_wstrb_o     = wstrb_q;
  assign bus.out_valid_o      = out_vld_q;
  assign bus.rf_rd_o          = o_rd_q;
  assign bus.rf_wen_o         = o_wen_q;
  assign bus.rf_wdata_o       = o_wdata_q;
  assign bus.pc_o             = o_pc_q;
  assign bus.exit_o           = o_exit_q;
`ifdef MEM_MISALIGN_TRAP_EN
  assign bus.misaligned_o     = mis_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: vector table, hand-written corner sequences, and random ops against a byte-level reference model.
module tb_mem_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_stage_if bus ();
  mem_stage dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [3:0]  op;
    logic [63:0] addr, sdata, rdata;
    logic [4:0]  rd;
    logic        wen;
    int          rdy, rsp;
    logic [63:0] exp_data;
    logic        exp_wen;
    logic [7:0]  exp_strb;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int op_bytes(input logic [3:0] op);
    case (op)
      4'd1, 4'd5, 4'd8:  return 1;
      4'd2, 4'd6, 4'd9:  return 2;
      4'd3, 4'd7, 4'd10: return 4;
      default:           return 8;
    endcase
  endfunction

  function automatic int eff_off(input logic [3:0] op, input logic [63:0] addr);
    int o = int'(addr[2:0]);
    return o - (o % op_bytes(op));
  endfunction

  function automatic logic [63:0] ref_load(input logic [3:0] op, input logic [63:0] addr, input logic [63:0] rdata);
    int sz = op_bytes(op);
    int off = eff_off(op, addr);
    logic [63:0] v = '0;
    logic [63:0] ones = '1;
    for (int i = sz - 1; i >= 0; i--) v = (v << 8) | 64'(rdata[8*(off+i) +: 8]);
    if (op >= 4'd1 && op <= 4'd3 && v[8*sz-1]) v = v | (ones << (8*sz));
    return v;
  endfunction

  function automatic logic [7:0] ref_strb(input logic [3:0] op, input logic [63:0] addr);
    int off = eff_off(op, addr);
    logic [7:0] s = '0;
    for (int i = 0; i < 8; i++) if (i >= off && i < off + op_bytes(op)) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] ref_wlanes(input logic [3:0] op, input logic [63:0] addr, input logic [63:0] sdata);
    int off = eff_off(op, addr);
    logic [63:0] m = '0;
    for (int i = off; i < off + op_bytes(op); i++) m[8*i +: 8] = sdata[8*(i-off) +: 8];
    return m;
  endfunction

  function automatic vec_t mk(input string tag, input logic [3:0] op, input logic [63:0] addr, input logic [63:0] sdata,
                              input logic [63:0] rdata, input logic [4:0] rd, input logic wen, input int rdy, input int rsp,
                              input logic [63:0] exp_data, input logic exp_wen, input logic [7:0] exp_strb);
    vec_t v;
    v.tag = tag; v.op = op; v.addr = addr; v.sdata = sdata; v.rdata = rdata; v.rd = rd; v.wen = wen;
    v.rdy = rdy; v.rsp = rsp; v.exp_data = exp_data; v.exp_wen = exp_wen; v.exp_strb = exp_strb;
    return v;
  endfunction

  // Drives one instruction through the stage and checks every phase; all waits are fixed-length.
  task automatic run_op(input vec_t v);
    logic [63:0] mask = '0;
    logic [63:0] pc = ~v.addr;
    logic        ex = v.addr[4];
    bit is_none = (v.op == 4'd0) || (v.op >= 4'd12);
    bit is_store = (v.op >= 4'd8) && (v.op <= 4'd11);
    for (int i = 0; i < 8; i++) if (v.exp_strb[i]) mask[8*i +: 8] = 8'hFF;
    chk({v.tag, ".in_ready_pre"}, 64'(bus.in_ready_o), 64'd1);
    bus.in_valid_i = 1'b1; bus.memop_i = v.op; bus.aluout_i = v.addr; bus.store_data_i = v.sdata;
    bus.rf_rd_i = v.rd; bus.rf_wen_i = v.wen; bus.pc_i = pc; bus.exit_i = ex;
    step();
    bus.in_valid_i = 1'b0;
    if (!is_none) begin
      for (int c = 0; c <= v.rdy; c++) begin
        chk({v.tag, ".req_valid"}, 64'(bus.dmem_req_valid_o), 64'd1);
        chk({v.tag, ".in_ready_busy"}, 64'(bus.in_ready_o), 64'd0);
        chk({v.tag, ".addr"}, bus.dmem_addr_o, v.addr & ~64'h7);
        chk({v.tag, ".dmem_wen"}, 64'(bus.dmem_wen_o), 64'(is_store));
        chk({v.tag, ".wstrb"}, 64'(bus.dmem_wstrb_o), 64'(v.exp_strb));
        if (is_store) chk({v.tag, ".wdata"}, bus.dmem_wdata_o & mask, v.exp_data);
        if (c == v.rdy) bus.dmem_req_ready_i = 1'b1;
        step();
      end
      bus.dmem_req_ready_i = 1'b0;
      if (!is_store) begin
        chk({v.tag, ".req_dropped"}, 64'(bus.dmem_req_valid_o), 64'd0);
        for (int c = 0; c <= v.rsp; c++) begin
          chk({v.tag, ".no_out_yet"}, 64'(bus.out_valid_o), 64'd0);
          chk({v.tag, ".in_ready_wait"}, 64'(bus.in_ready_o), 64'd0);
          if (c == v.rsp) begin
            bus.dmem_resp_valid_i = 1'b1;
            bus.dmem_rdata_i = v.rdata;
          end
          step();
        end
        bus.dmem_resp_valid_i = 1'b0;
      end
    end
    chk({v.tag, ".out_valid"}, 64'(bus.out_valid_o), 64'd1);
    chk({v.tag, ".rf_rd"}, 64'(bus.rf_rd_o), 64'(v.rd));
    chk({v.tag, ".rf_wen"}, 64'(bus.rf_wen_o), 64'(v.exp_wen));
    if (!is_store) chk({v.tag, ".rf_wdata"}, bus.rf_wdata_o, v.exp_data);
    chk({v.tag, ".pc"}, bus.pc_o, pc);
    chk({v.tag, ".exit"}, 64'(bus.exit_o), 64'(ex));
    chk({v.tag, ".in_ready_post"}, 64'(bus.in_ready_o), 64'd1);
    step();
    chk({v.tag, ".out_pulse"}, 64'(bus.out_valid_o), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    bus.in_valid_i = 0; bus.rf_rd_i = 0; bus.rf_wen_i = 0; bus.aluout_i = 0; bus.store_data_i = 0;
    bus.memop_i = 0; bus.pc_i = 0; bus.exit_i = 0; bus.dmem_req_ready_i = 0; bus.dmem_resp_valid_i = 0;
    bus.dmem_rdata_i = 0;

    vecs.push_back(mk("none",     4'd0,  64'h1234, 0, 0, 5'd5, 1, 0, 0, 64'h1234, 1, 8'h00));
    vecs.push_back(mk("lb",       4'd1,  64'h1003, 0, 64'h0000_0000_8000_0000, 5'd7, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FF80, 1, 8'h00));
    vecs.push_back(mk("lwu",      4'd7,  64'h1004, 0, 64'h8765_4321_0000_0000, 5'd8, 1, 1, 0, 64'h0000_0000_8765_4321, 1, 8'h00));
    vecs.push_back(mk("sh",       4'd9,  64'h2006, 64'hBEEF, 0, 5'd3, 1, 3, 0, 64'hBEEF_0000_0000_0000, 0, 8'hC0));
    vecs.push_back(mk("lh",       4'd2,  64'h0102, 0, 64'h0000_0000_F00D_0000, 5'd9, 1, 1, 0, 64'hFFFF_FFFF_FFFF_F00D, 1, 8'h00));
    vecs.push_back(mk("lhu",      4'd6,  64'h0102, 0, 64'h0000_0000_F00D_0000, 5'd10, 1, 0, 2, 64'h0000_0000_0000_F00D, 1, 8'h00));
    vecs.push_back(mk("ld",       4'd4,  64'h3008, 0, 64'h8000_0000_0000_0001, 5'd31, 1, 0, 0, 64'h8000_0000_0000_0001, 1, 8'h00));
    vecs.push_back(mk("lbu",      4'd5,  64'h0007, 0, 64'hAB00_0000_0000_0000, 5'd11, 1, 0, 0, 64'h0000_0000_0000_00AB, 1, 8'h00));
    vecs.push_back(mk("sb",       4'd8,  64'h0005, 64'h1122_3344_5566_77EE, 0, 5'd12, 1, 0, 0, 64'h0000_EE00_0000_0000, 0, 8'h20));
    vecs.push_back(mk("sw",       4'd10, 64'h0004, 64'hDEAD_BEEF, 0, 5'd13, 1, 1, 0, 64'hDEAD_BEEF_0000_0000, 0, 8'hF0));
    vecs.push_back(mk("sd",       4'd11, 64'h0010, 64'h0123_4567_89AB_CDEF, 0, 5'd14, 1, 2, 0, 64'h0123_4567_89AB_CDEF, 0, 8'hFF));
    vecs.push_back(mk("lw_rd0",   4'd3,  64'h0000, 0, 64'h0000_0000_7FFF_FFFF, 5'd0, 1, 0, 0, 64'h0000_0000_7FFF_FFFF, 0, 8'h00));
    vecs.push_back(mk("op13",     4'd13, 64'hCAFE, 0, 0, 5'd4, 1, 0, 0, 64'hCAFE, 1, 8'h00));
    vecs.push_back(mk("none_rd0", 4'd0,  64'h0055, 0, 0, 5'd0, 1, 0, 0, 64'h0055, 0, 8'h00));
    vecs.push_back(mk("none_w0",  4'd0,  64'h0066, 0, 0, 5'd6, 0, 0, 0, 64'h0066, 0, 8'h00));

    repeat (3) step();
    rst = 1'b0;
    chk("reset.in_ready", 64'(bus.in_ready_o), 64'd1);
    chk("reset.out_valid", 64'(bus.out_valid_o), 64'd0);
    chk("reset.req_valid", 64'(bus.dmem_req_valid_o), 64'd0);
    chk("reset.rf_wdata", bus.rf_wdata_o, 64'd0);
    chk("reset.wstrb", 64'(bus.dmem_wstrb_o), 64'd0);

    foreach (vecs[i]) run_op(vecs[i]);

    // Back-to-back NONE ops at full throughput.
    for (int k = 0; k < 3; k++) begin
      bus.in_valid_i = 1'b1; bus.memop_i = 4'd0; bus.aluout_i = 64'h100 + 64'(k);
      bus.rf_rd_i = 5'(k + 1); bus.rf_wen_i = 1'b1;
      step();
      chk("b2b.out_valid", 64'(bus.out_valid_o), 64'd1);
      chk("b2b.rf_wdata", bus.rf_wdata_o, 64'h100 + 64'(k));
      chk("b2b.in_ready", 64'(bus.in_ready_o), 64'd1);
    end
    bus.in_valid_i = 1'b0;
    step();
    chk("b2b.drain", 64'(bus.out_valid_o), 64'd0);

    bus.dmem_resp_valid_i = 1'b1;
    step();
    bus.dmem_resp_valid_i = 1'b0;
    chk("stray_resp.out_valid", 64'(bus.out_valid_o), 64'd0);
    chk("stray_resp.in_ready", 64'(bus.in_ready_o), 64'd1);
    step();
    chk("stray_resp.out_valid2", 64'(bus.out_valid_o), 64'd0);

    // Reset while waiting for load data; the late response must be dropped.
    bus.in_valid_i = 1'b1; bus.memop_i = 4'd4; bus.aluout_i = 64'h40; bus.rf_rd_i = 5'd2; bus.rf_wen_i = 1'b1;
    step();
    bus.in_valid_i = 1'b0; bus.dmem_req_ready_i = 1'b1;
    step();
    bus.dmem_req_ready_i = 1'b0;
    chk("rstwait.in_wait", 64'(bus.in_ready_o), 64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstwait.in_ready", 64'(bus.in_ready_o), 64'd1);
    bus.dmem_resp_valid_i = 1'b1; bus.dmem_rdata_i = 64'hFFFF_0000_FFFF_0000;
    step();
    bus.dmem_resp_valid_i = 1'b0;
    chk("rstwait.out_valid", 64'(bus.out_valid_o), 64'd0);
    chk("rstwait.req_valid", 64'(bus.dmem_req_valid_o), 64'd0);
    chk("rstwait.in_ready2", 64'(bus.in_ready_o), 64'd1);
    step();
    chk("rstwait.out_valid2", 64'(bus.out_valid_o), 64'd0);

`ifdef MEM_MISALIGN_TRAP_EN
    bus.in_valid_i = 1'b1; bus.memop_i = 4'd3; bus.aluout_i = 64'h1002; bus.rf_rd_i = 5'd9; bus.rf_wen_i = 1'b1;
    step();
    bus.in_valid_i = 1'b0;
    chk("mis.req_valid", 64'(bus.dmem_req_valid_o), 64'd0);
    chk("mis.out_valid", 64'(bus.out_valid_o), 64'd1);
    chk("mis.flag", 64'(bus.misaligned_o), 64'd1);
    chk("mis.rf_wen", 64'(bus.rf_wen_o), 64'd0);
    chk("mis.in_ready", 64'(bus.in_ready_o), 64'd1);
    step();
    chk("mis.flag_clear", 64'(bus.misaligned_o), 64'd0);
`else
    run_op(mk("lw_mis", 4'd3, 64'h1002, 0, 64'h1111_2222_8000_0001, 5'd9, 1, 0, 0, 64'hFFFF_FFFF_8000_0001, 1, 8'h00));
`endif

    for (int n = 0; n < 150; n++) begin
      bit ld, st;
      v.tag = "rand";
      v.op = 4'($urandom_range(0, 15));
      v.addr = {$urandom, $urandom};
      v.sdata = {$urandom, $urandom};
      v.rdata = {$urandom, $urandom};
      v.rd = 5'($urandom_range(0, 31));
      v.wen = 1'($urandom_range(0, 1));
      v.rdy = $urandom_range(0, 2);
      v.rsp = $urandom_range(0, 2);
      ld = (v.op >= 4'd1) && (v.op <= 4'd7);
      st = (v.op >= 4'd8) && (v.op <= 4'd11);
`ifdef MEM_MISALIGN_TRAP_EN
      if (ld || st) v.addr = v.addr & ~64'(op_bytes(v.op) - 1);
`endif
      v.exp_wen = v.wen && (v.rd != 0) && !st;
      v.exp_strb = st ? ref_strb(v.op, v.addr) : 8'h00;
      if (ld) v.exp_data = ref_load(v.op, v.addr, v.rdata);
      else if (st) v.exp_data = ref_wlanes(v.op, v.addr, v.sdata);
      else v.exp_data = v.addr;
      run_op(v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
